// File: rtl/warp_ibuffer_arb_pkg.sv
// Shared definitions for the warp instruction buffer. Decode and issue use the
// same values: default warp count, buffer depth, and the layout of the packed
// decoded instruction.
package warp_ibuffer_arb_pkg;

    localparam int IBUF_NUM_WARPS = 4;
    localparam int IBUF_DEPTH     = 2;
    localparam int IBUF_WIDW      = $clog2(IBUF_NUM_WARPS);

    // Field widths of the packed decoded instruction
    localparam int TMASK_W = IBUF_NUM_WARPS;
    localparam int PC_W    = 32;
    localparam int EX_W    = 3;
    localparam int OP_W    = 4;
    localparam int REG_W   = 5;
    localparam int IMM_W   = 32;
    localparam int FLAGS_W = 6;

    // LSB offsets, packed from flags (bit 0) up to tmask (MSBs)
    localparam int FLAGS_LSB = 0;
    localparam int IMM_LSB   = FLAGS_LSB + FLAGS_W;
    localparam int RS2_LSB   = IMM_LSB + IMM_W;
    localparam int RS1_LSB   = RS2_LSB + REG_W;
    localparam int RD_LSB    = RS1_LSB + REG_W;
    localparam int OP_LSB    = RD_LSB + REG_W;
    localparam int EX_LSB    = OP_LSB + OP_W;
    localparam int PC_LSB    = EX_LSB + EX_W;
    localparam int TMASK_LSB = PC_LSB + PC_W;

    // Total payload width (96 with the default four warps)
    localparam int IBUF_DATAW = TMASK_LSB + TMASK_W;

endpackage

// File: rtl/warp_ibuf_fifo.sv
// Single-warp circular instruction FIFO with occupancy count, full and empty.
module warp_ibuf_fifo
    import warp_ibuffer_arb_pkg::*;
#(
    parameter int DEPTH = IBUF_DEPTH,
    parameter int DATAW = IBUF_DATAW,
    localparam int PTRW = $clog2(DEPTH),
    localparam int CNTW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [DATAW-1:0] wr_data,
    input  logic             rd_en,
    output logic [DATAW-1:0] rd_data,
    output logic [CNTW-1:0]  count,
    output logic             full,
    output logic             empty
);

    logic [DATAW-1:0] mem [DEPTH];
    logic [PTRW-1:0]  wr_ptr;
    logic [PTRW-1:0]  rd_ptr;

    assign full    = (count == CNTW'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // Payload storage; contents are don't-care until counted valid
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    // Pointers wrap naturally (DEPTH is a power of two); count tracks net fill
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTRW'(1);
            if (rd_en) rd_ptr <= rd_ptr + PTRW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

    // Writing a full buffer or reading an empty one means the arbiter is broken
    always_ff @(posedge clk) begin
        if (reset) begin
            assert (!(wr_en && full));
            assert (!(rd_en && empty));
        end
    end

endmodule

// File: rtl/warp_ibuffer_arb.sv
// Per-warp instruction buffer between decode and issue: one private FIFO per
// warp, round-robin selection of a head entry, and a grant lock that holds the
// offered warp steady while issue back-pressures.
module warp_ibuffer_arb
    import warp_ibuffer_arb_pkg::*;
#(
    parameter int NUM_WARPS = IBUF_NUM_WARPS,
    parameter int DEPTH     = IBUF_DEPTH,
    parameter int DATAW     = IBUF_DATAW,
    localparam int WIDW = $clog2(NUM_WARPS),
    localparam int CNTW = $clog2(DEPTH + 1),
    localparam int OCCW = $clog2(NUM_WARPS * DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 freeze,
    input  logic                 enq_valid,
    input  logic [WIDW-1:0]      enq_wid,
    input  logic [DATAW-1:0]     enq_data,
    output logic                 enq_ready,
    output logic                 deq_valid,
    output logic [WIDW-1:0]      deq_wid,
    output logic [DATAW-1:0]     deq_data,
    input  logic                 deq_ready,
    output logic [NUM_WARPS-1:0] warp_empty,
    output logic [OCCW-1:0]      occupancy
);

    logic [NUM_WARPS-1:0]            full;
    logic [NUM_WARPS-1:0]            wr_en;
    logic [NUM_WARPS-1:0]            rd_en;
    logic [NUM_WARPS-1:0][DATAW-1:0] head;
    logic [NUM_WARPS-1:0][CNTW-1:0]  count;
    logic [NUM_WARPS-1:0]            cand;

    logic [WIDW-1:0] rr_ptr;
    logic            lock_valid;
    logic [WIDW-1:0] lock_wid;
    logic [WIDW-1:0] rr_pick;
    logic [WIDW-1:0] idx;
    logic            found;
    logic [WIDW-1:0] grant;
    logic            enq_fire;
    logic            deq_fire;

    // Enqueue admission looks only at the target's full flag, never at deq_ready
    assign enq_ready = ~full[enq_wid];
    assign enq_fire  = enq_valid & enq_ready;

    assign cand      = ~warp_empty;
    assign grant     = lock_valid ? lock_wid : rr_pick;
    assign deq_valid = (|cand) & ~freeze;
    assign deq_wid   = grant;
    assign deq_data  = head[grant];
    assign deq_fire  = deq_valid & deq_ready;

    genvar w;
    generate
        for (w = 0; w < NUM_WARPS; w++) begin : g_warp
            assign wr_en[w] = enq_fire && (enq_wid == WIDW'(w));
            assign rd_en[w] = deq_fire && (grant == WIDW'(w));

            warp_ibuf_fifo #(
                .DEPTH (DEPTH),
                .DATAW (DATAW)
            ) u_fifo (
                .clk     (clk),
                .reset   (reset),
                .wr_en   (wr_en[w]),
                .wr_data (enq_data),
                .rd_en   (rd_en[w]),
                .rd_data (head[w]),
                .count   (count[w]),
                .full    (full[w]),
                .empty   (warp_empty[w])
            );
        end
    endgenerate

    // Round-robin search: first non-empty warp at or after rr_ptr, wrapping
    always_comb begin
        rr_pick = rr_ptr;
        found   = 1'b0;
        idx     = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            idx = rr_ptr + WIDW'(i);
            if (!found && cand[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    end

    // Total occupancy straight from the registered per-warp counts
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            occupancy = occupancy + OCCW'(count[i]);
        end
    end

    // Advance rr past the issued warp; lock a stalled grant until it fires.
    // Under freeze deq_valid is low, so neither rr nor the lock moves.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr     <= '0;
            lock_valid <= 1'b0;
            lock_wid   <= '0;
        end else if (deq_fire) begin
            rr_ptr     <= grant + WIDW'(1);
            lock_valid <= 1'b0;
        end else if (deq_valid) begin
            lock_valid <= 1'b1;
            lock_wid   <= grant;
        end
    end

endmodule

// File: doc/warp_ibuffer_arb.md
Name: warp_ibuffer_arb

Overview:
- Per-warp instruction buffer between decode and issue.
- Accepts one decoded instruction per cycle tagged with a warp id and queues it in that warp's private FIFO.
- Presents one head-of-queue instruction per cycle to the issue stage, chosen round-robin across non-empty warps.
- Keeps the grant stable under back-pressure, so issue sees valid/data held until accepted.

Parameters:
- NUM_WARPS, 4, number of warps; power of two, at least 2.
- DEPTH, 2, entries per warp FIFO; power of two, at least 2.
- DATAW, 96, width of the packed decoded-instruction payload (tmask, PC, ex/op fields, rd/rs, imm, flags).
- WIDW, $clog2(NUM_WARPS), warp id width; derived, not overridable.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- freeze  in  1  when high, blocks dequeue; enqueue is unaffected.
- enq_valid  in  1  decode presents an instruction.
- enq_wid  in  WIDW  warp id of the enqueued instruction.
- enq_data  in  DATAW  packed decoded instruction.
- enq_ready  out  1  buffer of enq_wid can accept.
- deq_valid  out  1  an instruction is offered to issue.
- deq_wid  out  WIDW  warp id of the offered instruction.
- deq_data  out  DATAW  offered instruction.
- deq_ready  in  1  issue accepts; this is the scoreboard-clear AND execute-ready term.
- warp_empty  out  NUM_WARPS  per-warp FIFO empty flags, used by the warp scheduler.
- occupancy  out  $clog2(NUM_WARPS*DEPTH+1)  total queued entries, for perf counters.

Behaviour:
- Handshake:
  - enq fire = enq_valid & enq_ready.
  - deq fire = deq_valid & deq_ready.
  - Both may fire in the same cycle.
- Reset:
  - Reset is asynchronous on assertion and synchronously released.
  - All read/write pointers and counts go to 0; rr_ptr = 0; grant lock cleared.
  - Outputs during reset: deq_valid = 0, enq_ready = 1, warp_empty = all ones, occupancy = 0.
  - Reset asserted mid-transfer discards all queued entries; nothing is replayed.
- Per-warp FIFO:
  - Circular buffer of DEPTH entries with a count of width $clog2(DEPTH+1).
  - Full when count == DEPTH; empty when count == 0.
  - Pointers wrap modulo DEPTH.
- Enqueue:
  - enq_ready = ~full[enq_wid]. It depends only on the full flag, with no same-cycle pass-through when full.
  - A full warp that dequeues this cycle still shows enq_ready = 0.
  - Data is written at the clock edge.
- Latency:
  - An enqueued entry is first visible on deq one cycle after enq fire.
  - There is no combinational bypass from enq to deq.
- Arbitration:
  - Candidates = ~warp_empty.
  - Selection: the first candidate at or after rr_ptr, searching upward modulo NUM_WARPS.
  - On deq fire, rr_ptr <= granted wid + 1 (mod NUM_WARPS).
- Grant lock:
  - When deq_valid & ~deq_ready & ~freeze, the granted wid is latched.
  - While latched, the next cycle keeps the same wid/data even if other warps become non-empty.
  - The lock is released on deq fire.
- Freeze:
  - deq_valid = 0; no rr_ptr advance; lock contents held.
  - After freeze deasserts, the locked warp is re-offered first.
- deq_data: combinational from the granted warp's head entry. deq_valid = |candidates & ~freeze.
- Same-warp enqueue and dequeue in one cycle: count unchanged, both pointers advance.
- Counts:
  - occupancy = sum of per-warp counts, registered-consistent (it reflects state after the last edge).
  - Enqueue to a full warp never happens, because enq_ready = 0.
  - Simulation assertions: fire into full, and dequeue from an empty warp, are errors.
- Combinational paths:
  - deq_ready does not combinationally affect enq_ready.
  - No path from deq_ready to deq_valid.

Decomposition:
- Shared package/header holds NUM_WARPS, the WIDW derivation, and the packed-instruction field offsets making up DATAW. These are common with the decode and issue stages.
- One natural sub-module: warp_ibuf_fifo, a single-warp DEPTH-entry circular FIFO with count, full and empty. It is instantiated NUM_WARPS times in a generate loop.
- The arbiter and lock live in the top module.

Test Plan:
- Reset, then enq warp2 data 0xA5 at cycle 0:
  - Expect deq_valid = 0 at cycle 0.
  - Expect deq_valid = 1, deq_wid = 2, deq_data = 0xA5 at cycle 1.
  - Expect warp_empty = 4'b1011, occupancy = 1.
- Fill warp1 with 2 entries (DEPTH = 2) while deq_ready = 0:
  - Third enq to warp1 sees enq_ready = 0.
  - Enq to warp3 in the same cycle sees enq_ready = 1.
  - occupancy reaches 3.
- Warps 0, 1, 3 each hold one entry, deq_ready = 1 every cycle:
  - Issue order is 0, 1, 3.
  - rr_ptr then = 0; a new warp1 entry is served before warp0's new entry if rr_ptr has passed 0.
- Grant lock: warp3 granted with deq_ready = 0, then warp0 enqueues.
  - deq_wid stays 3 with data unchanged for 3 stall cycles.
  - On deq_ready = 1, warp3 fires; warp0 is offered next cycle.
- freeze = 1 with 2 warps non-empty: deq_valid = 0 and enqueue still accepted.
  - After freeze drops, the previously locked warp is offered first.
- Async reset asserted mid-stream with 5 entries queued:
  - Immediately deq_valid = 0, occupancy = 0, warp_empty = all ones.
  - After release, the first enq to warp0 appears one cycle later.
